// File: rtl/vedic_mul_pkg.sv
// Shared definitions for the vedic multiplier round-robin scheduler slice.
//   N_REQ_DEF / WIDTH_DEF / MUL_LAT_DEF / IDW_DEF : default parameterisation
//   tag_t    : in-flight issue tag {vld, id} at the default ID width
//   wrap_inc : modulo-n increment used for the round-robin pointer
package vedic_mul_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned IDW_DEF     = 2;

  typedef struct packed {
    logic               vld;
    logic [IDW_DEF-1:0] id;
  } tag_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-requester request bits
//   ptr   : highest-priority requester index for this cycle
//   en    : 0 forces no grant
//   grant : one-hot grant (all zero when nothing wins)
//   idx   : encoded index of the granted requester (0 when no grant)
module rr_arbiter
  import vedic_mul_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDW   = IDW_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        j = 32'(ptr) + i;
        if (j >= N_REQ) j = j - N_REQ;
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vedic_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among N_REQ requesters.
//   clk, rst                : clock, synchronous active-high reset
//   en                      : 1 allows new grants; 0 lets in-flight ops drain
//   req_valid/req_ready     : per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b             : packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a/mul_b             : registered operands to the multiplier
//   mul_p                   : multiplier product, valid MUL_LAT clocks after mul_a/mul_b
//   resp_valid/resp_id/resp_p : one-hot response pulse, owner id, product
//   busy                    : any issue tag still in flight
module vedic_mul_rr_sched
  import vedic_mul_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned IDW     = IDW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [2*WIDTH-1:0]     resp_p,
  output logic                   busy
);

  logic [IDW-1:0]   rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gnt_idx;
  logic             fire;

  // Tag captured alongside mul_a/mul_b, then MUL_LAT shift stages: the last
  // stage lines up with the cycle in which mul_p holds that issue's product.
  logic             iss_vld;
  logic [IDW-1:0]   iss_id;
  logic [MUL_LAT-1:0] pipe_vld;
  logic [IDW-1:0]   pipe_id [MUL_LAT];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (en & ~rst),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = grant;
  assign fire      = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      iss_vld <= 1'b0;
      iss_id  <= '0;
    end else begin
      iss_vld <= fire;
      iss_id  <= gnt_idx;
      if (fire) begin
        mul_a  <= req_a[32'(gnt_idx)*WIDTH +: WIDTH];
        mul_b  <= req_b[32'(gnt_idx)*WIDTH +: WIDTH];
        rr_ptr <= IDW'(wrap_inc(32'(gnt_idx), N_REQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int unsigned s = 0; s < MUL_LAT; s++) pipe_id[s] <= '0;
    end else begin
      pipe_vld[0] <= iss_vld;
      pipe_id[0]  <= iss_id;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (pipe_vld[MUL_LAT-1]) resp_valid[pipe_id[MUL_LAT-1]] = 1'b1;
  end

  assign resp_id = pipe_id[MUL_LAT-1];
  assign resp_p  = mul_p;
  assign busy    = iss_vld | (|pipe_vld);

endmodule
